req_encoder4to2: RTL and testbench

REQ_ENCODER4TO2 -- requirements
Module: req_encoder4to2

---
 rtl/req_encoder4to2_pkg.sv | 26 ++
 rtl/req_encoder4to2_pri_sel4.sv | 38 +++
 rtl/req_encoder4to2.sv | 120 ++++++++++++
 tb/tb_req_encoder4to2.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/req_encoder4to2_pkg.sv
// Shared constants, FSM state type and helpers for the 4-to-2 request encoder.
package req_encoder4to2_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned CODE_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic [N_REQ-1:0]  req_vec_t;
  typedef logic [CODE_W-1:0] code_t;

  // Grant payload as seen by the consumer.
  typedef struct packed {
    logic  valid;
    code_t code;
  } grant_t;

  // Decode a binary request index into its one-hot bit.
  function automatic req_vec_t onehot(input code_t c);
    return req_vec_t'(1) << c;
  endfunction

endpackage

// File: rtl/req_encoder4to2_pri_sel4.sv
// pri_sel4: rotating first-set search over a 4-bit candidate vector.
// Starting at index `start`, scans upward with wrap 3 -> 0 and returns the
// first set index. `any` flags that at least one candidate bit is set.
//   cand  : candidate request vector
//   start : index searched first
//   idx   : selected index (don't-care when any = 0)
//   any   : at least one candidate set
module pri_sel4
  import req_encoder4to2_pkg::*;
(
  input  logic [N_REQ-1:0]  cand,
  input  logic [CODE_W-1:0] start,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  logic [N_REQ-1:0]  rot;
  logic [CODE_W-1:0] pos;
  logic [CODE_W-1:0] off;

  // Rotate so that `start` lands at bit 0, then take the lowest set bit.
  always_comb begin
    rot = '0;
    pos = '0;
    off = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      pos    = start + CODE_W'(i);
      rot[i] = cand[pos];
    end
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) off = CODE_W'(i);
    end
  end

  assign idx = start + off;
  assign any = |cand;

endmodule

// File: rtl/req_encoder4to2.sv
// req_encoder4to2: captures request pulses/levels into a pending vector and
// issues one binary-coded grant at a time over a valid/ready handshake.
// ROUND_ROBIN = 0 gives fixed priority (bit 3 highest); 1 rotates the search
// start to one past the last accepted code.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i      : request lines, sampled every edge
//   ready_i    : consumer accepts code_o when high with valid_o
//   code_o     : granted index (registered)
//   valid_o    : grant outstanding (registered)
//   pending_o  : captured, not-yet-served requests (registered)
//   multi_o    : another request is pending besides the granted one
module req_encoder4to2
  import req_encoder4to2_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_i,
  input  logic              ready_i,
  output logic [CODE_W-1:0] code_o,
  output logic              valid_o,
  output logic [N_REQ-1:0]  pending_o,
  output logic              multi_o
);

  localparam bit RR = (ROUND_ROBIN != 0);

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] ptr_q, ptr_d;

  logic              handshake;
  logic [N_REQ-1:0]  served;
  logic [N_REQ-1:0]  cand;
  logic [N_REQ-1:0]  cand_rev;
  logic [N_REQ-1:0]  sel_cand;
  logic [CODE_W-1:0] rr_start;
  logic [CODE_W-1:0] sel_start;
  logic [CODE_W-1:0] sel_idx;
  logic              sel_any;
  logic [CODE_W-1:0] sel_code;

  // Candidate set: pending minus the bit being served, plus new requests.
  // A request on the served bit re-sets it, so the new request wins.
  assign handshake = (state_q == HOLD) && ready_i;
  assign served    = handshake ? onehot(code_q) : '0;
  assign cand      = (pending_q & ~served) | req_i;
  assign rr_start  = handshake ? (code_q + CODE_W'(1)) : ptr_q;

  // Fixed priority reuses the upward search on the bit-reversed vector;
  // reversing the found index back is a bitwise invert for 2-bit codes.
  always_comb begin
    cand_rev = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      cand_rev[i] = cand[int'(N_REQ) - 1 - i];
    end
  end

  assign sel_cand  = RR ? cand : cand_rev;
  assign sel_start = RR ? rr_start : '0;
  assign sel_code  = RR ? sel_idx : ~sel_idx;

  pri_sel4 u_pri_sel4 (
    .cand  (sel_cand),
    .start (sel_start),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  // Next-state and grant selection.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    ptr_d     = ptr_q;
    pending_d = cand;
    if (handshake) ptr_d = code_q + CODE_W'(1);
    case (state_q)
      IDLE: begin
        if (sel_any) begin
          code_d  = sel_code;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          if (sel_any) begin
            code_d = sel_code;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      ptr_q     <= ptr_d;
    end
  end

  assign code_o    = code_q;
  assign valid_o   = (state_q == HOLD);
  assign pending_o = pending_q;
  // Decoded from registers only; no input reaches this output.
  assign multi_o   = valid_o & (|(pending_q & ~onehot(code_q)));

endmodule

// File: tb/tb_req_encoder4to2.sv
// Testbench for req_encoder4to2: one fixed-priority and one rotating instance.
// Stimulus pushes expected grant codes into per-instance queues; monitors pop
// and compare on every accepted grant. Registered outputs are also checked
// directly after each edge.
module tb_req_encoder4to2;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_a, req_b;
  logic       ready_a, ready_b;
  logic [1:0] code_a, code_b;
  logic       valid_a, valid_b;
  logic [3:0] pend_a, pend_b;
  logic       multi_a, multi_b;

  int checks = 0;
  int errors = 0;
  int q_a[$];
  int q_b[$];

  req_encoder4to2 #(.ROUND_ROBIN(0)) dut_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_a),
    .ready_i   (ready_a),
    .code_o    (code_a),
    .valid_o   (valid_a),
    .pending_o (pend_a),
    .multi_o   (multi_a)
  );

  req_encoder4to2 #(.ROUND_ROBIN(1)) dut_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_b),
    .ready_i   (ready_b),
    .code_o    (code_b),
    .valid_o   (valid_b),
    .pending_o (pend_b),
    .multi_o   (multi_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input int v, input int c, input int p, input int m);
    chk({name, ".valid"},   32'(valid_a), v);
    chk({name, ".code"},    32'(code_a),  c);
    chk({name, ".pending"}, 32'(pend_a),  p);
    chk({name, ".multi"},   32'(multi_a), m);
  endtask

  task automatic chk_b(input string name, input int v, input int c, input int p);
    chk({name, ".valid"},   32'(valid_b), v);
    chk({name, ".code"},    32'(code_b),  c);
    chk({name, ".pending"}, 32'(pend_b),  p);
  endtask

  // Scoreboard monitors: every accepted grant must match the queue head.
  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant_fp: unexpected grant code %0d, none expected", code_a);
      end else begin
        chk("grant_fp", 32'(code_a), q_a.pop_front());
      end
    end
    if (valid_b && ready_b) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant_rr: unexpected grant code %0d, none expected", code_b);
      end else begin
        chk("grant_rr", 32'(code_b), q_b.pop_front());
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    req_a   = '0;
    req_b   = '0;
    ready_a = 1'b0;
    ready_b = 1'b0;
    #2;
    chk_a("reset_fp", 0, 0, 0, 0);
    chk_b("reset_rr", 0, 0, 0);
    chk("reset_rr.multi", 32'(multi_b), 0);
    tick();
    rst_n = 1'b1;

    // Idle with ready high and no requests: nothing happens.
    ready_a = 1'b1;
    tick();
    chk_a("idle_ready", 0, 0, 0, 0);

    // Single request pulse, accepted immediately.
    req_a = 4'b0100; ready_a = 1'b1; q_a.push_back(2);
    tick();
    req_a = 4'b0000;
    chk_a("single_grant", 1, 2, 4'b0100, 0);
    tick();
    chk_a("single_done", 0, 2, 0, 0);

    // Fixed priority with backpressure.
    req_a = 4'b1011; ready_a = 1'b0;
    q_a.push_back(3); q_a.push_back(1); q_a.push_back(0);
    tick();
    req_a = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      chk_a($sformatf("bp_hold%0d", i), 1, 3, 4'b1011, 1);
      if (i == 3) ready_a = 1'b1;
      tick();
    end
    chk_a("bp_second", 1, 1, 4'b0011, 1);
    tick();
    chk_a("bp_third", 1, 0, 4'b0001, 0);
    tick();
    chk_a("bp_done", 0, 0, 0, 0);

    // Higher-priority arrival during HOLD does not disturb the grant.
    req_a = 4'b0010; ready_a = 1'b0;
    q_a.push_back(1); q_a.push_back(3);
    tick();
    req_a = 4'b1000;
    chk_a("stable_first", 1, 1, 4'b0010, 0);
    tick();
    req_a = 4'b0000;
    chk_a("stable_late", 1, 1, 4'b1010, 1);
    ready_a = 1'b1;
    tick();
    chk_a("stable_next", 1, 3, 4'b1000, 0);
    tick();
    chk_a("stable_done", 0, 3, 0, 0);

    // Same-bit collision on the handshake edge keeps the bit pending.
    req_a = 4'b0001; ready_a = 1'b0; q_a.push_back(0);
    tick();
    chk_a("coll_hold", 1, 0, 4'b0001, 0);
    req_a = 4'b0001; ready_a = 1'b1; q_a.push_back(0);
    tick();
    req_a = 4'b0000;
    chk_a("coll_after", 1, 0, 4'b0001, 0);
    tick();
    chk_a("coll_done", 0, 0, 0, 0);
    ready_a = 1'b0;

    // Rotating priority: all requests held, back-to-back grants.
    req_b = 4'b1111; ready_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q_b.push_back(0); q_b.push_back(1); q_b.push_back(2); q_b.push_back(3);
    end
    tick();
    chk_b("rr_g0", 1, 0, 4'b1111);
    tick(); chk_b("rr_g1", 1, 1, 4'b1111);
    tick(); chk_b("rr_g2", 1, 2, 4'b1111);
    tick(); chk_b("rr_g3", 1, 3, 4'b1111);
    tick(); chk_b("rr_g4", 1, 0, 4'b1111);
    req_b = 4'b0000;
    tick(); chk_b("rr_d1", 1, 1, 4'b1110);
    tick(); chk_b("rr_d2", 1, 2, 4'b1100);
    tick(); chk_b("rr_d3", 1, 3, 4'b1000);
    tick(); chk_b("rr_done", 0, 3, 0);

    // Rotation pointer is 0 after accepting code 3; wrap 1 -> 3.
    req_b = 4'b1010; ready_b = 1'b0;
    q_b.push_back(1); q_b.push_back(3);
    tick();
    req_b = 4'b0000;
    chk_b("rr_ptr_first", 1, 1, 4'b1010);
    chk("rr_ptr_multi", 32'(multi_b), 1);
    ready_b = 1'b1;
    tick();
    chk_b("rr_ptr_next", 1, 3, 4'b1000);
    tick();
    chk_b("rr_ptr_done", 0, 3, 0);
    ready_b = 1'b0;

    // Asynchronous reset in the middle of a HOLD cycle.
    req_a = 4'b0110; ready_a = 1'b0;
    tick();
    req_a = 4'b0000;
    chk_a("pre_reset", 1, 2, 4'b0110, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("mid_reset", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_a("post_reset", 0, 0, 0, 0);
    tick();

    chk("queue_fp_empty", q_a.size(), 0);
    chk("queue_rr_empty", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
